// File: rtl/riscv_muldiv_unit_if.sv
// riscv_muldiv_unit_if: request/response handshake bundle for the multiply/divide unit
interface riscv_muldiv_unit_if #(parameter int XLEN = 32, parameter int TAG_W = 5);
  logic req_valid;
  logic req_ready;
  logic [2:0] req_funct3;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [TAG_W-1:0] req_tag;
  logic resp_valid;
  logic resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [TAG_W-1:0] resp_tag;
  modport master (
    output req_valid, req_funct3, req_a, req_b, req_tag, resp_ready,
    input req_ready, resp_valid, resp_data, resp_tag
  );
  modport slave (
    input req_valid, req_funct3, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready request and response
module riscv_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic reset,
  input logic kill,
  output logic busy,
  riscv_muldiv_unit_if.slave bus
);
  localparam int N = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic neg;
  logic [XLEN-1:0] dvs;
  logic [2*XLEN-1:0] acc, acc_n, prod;
  logic [CW-1:0] cnt;
  logic accept, sgn_a, sgn_b, neg_a, neg_b, special, ge;
  logic [XLEN-1:0] mag_a, mag_b, spec_res, quo, remv, fin;
  logic [XLEN:0] rem, sum;
  assign accept = bus.req_valid & bus.req_ready;
  assign bus.req_ready = (state == IDLE) & !kill & !reset;
  assign bus.resp_valid = state == DONE;
  assign busy = state != IDLE;
  // Operand conditioning: signedness per funct3, magnitudes and the divide corner cases.
  always_comb begin
    sgn_a = bus.req_funct3[2] ? !bus.req_funct3[0] : (bus.req_funct3[1] ^ bus.req_funct3[0]);
    sgn_b = bus.req_funct3[2] ? !bus.req_funct3[0] : (bus.req_funct3[1:0] == 2'b01);
    neg_a = sgn_a & bus.req_a[XLEN-1];
    neg_b = sgn_b & bus.req_b[XLEN-1];
    mag_a = neg_a ? -bus.req_a : bus.req_a;
    mag_b = neg_b ? -bus.req_b : bus.req_b;
    special = bus.req_funct3[2] & ((bus.req_b == '0) | (!bus.req_funct3[0] & &bus.req_b &
              (bus.req_a == {1'b1, {(XLEN-1){1'b0}}})));
    spec_res = (bus.req_b == '0) ? (bus.req_funct3[1] ? bus.req_a : '1)
                                 : (bus.req_funct3[1] ? '0 : bus.req_a);
  end
  // acc holds {partial product, multiplier} for multiplies and {remainder, quotient} for divides.
  always_comb begin
    acc_n = acc;
    rem = '0;
    sum = '0;
    ge = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op[2]) begin
        rem = {acc_n[2*XLEN-1:XLEN], acc_n[XLEN-1]};
        ge = rem >= {1'b0, dvs};
        rem = ge ? rem - {1'b0, dvs} : rem;
        acc_n = {rem[XLEN-1:0], acc_n[XLEN-2:0], ge};
      end else begin
        sum = {1'b0, acc_n[2*XLEN-1:XLEN]} + (acc_n[0] ? {1'b0, dvs} : '0);
        acc_n = {sum, acc_n[XLEN-1:1]};
      end
    end
    prod = neg ? -acc_n : acc_n;
    quo = neg ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    remv = neg ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
    fin = op[2] ? (op[1] ? remv : quo) : ((op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_comb begin
    state_n = kill ? IDLE
            : (state == IDLE) ? (accept ? (special ? DONE : CALC) : IDLE)
            : (state == CALC) ? ((cnt == LAST) ? DONE : CALC)
            : (bus.resp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_data <= '0;
      bus.resp_tag <= '0;
    end else begin
      if (accept) begin
        op <= bus.req_funct3;
        neg <= (bus.req_funct3[2] & bus.req_funct3[1]) ? neg_a : neg_a ^ neg_b;
        dvs <= mag_b;
        acc <= {{XLEN{1'b0}}, mag_a};
        cnt <= '0;
        bus.resp_tag <= bus.req_tag;
        if (special) bus.resp_data <= spec_res;
      end
      if (state == CALC) begin
        acc <= acc_n;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) bus.resp_data <= fin;
      end
    end
  end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit: directed checks of latency, results, backpressure, kill and reset
module tb_riscv_muldiv_unit;
  logic clk = 1'b0, reset = 1'b1, kill = 1'b0, busy, busy4;
  int checks = 0, failures = 0;
  riscv_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) bus ();
  riscv_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) bus4 ();
  riscv_muldiv_unit #(.XLEN(32), .UNROLL(1), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .kill(kill), .busy(busy), .bus(bus)
  );
  riscv_muldiv_unit #(.XLEN(32), .UNROLL(4), .TAG_W(5)) dut4 (
    .clk(clk), .reset(reset), .kill(1'b0), .busy(busy4), .bus(bus4)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic [31:0] ed, input int lat);
    int cyc;
    logic rr;
    bus.req_funct3 = f; bus.req_a = a; bus.req_b = b; bus.req_tag = t; bus.req_valid = 1'b1;
    chk({nm, "_accept_ready"}, 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0; bus.req_a = ~a; bus.req_b = ~b; bus.req_tag = ~t;
    cyc = 1; rr = 1'b0;
    while (!bus.resp_valid && cyc < 100) begin
      rr |= bus.req_ready;
      tick();
      cyc++;
    end
    rr |= bus.req_ready;
    chk({nm, "_latency"}, 64'(cyc), 64'(lat));
    chk({nm, "_data"}, 64'(bus.resp_data), 64'(ed));
    chk({nm, "_tag"}, 64'(bus.resp_tag), 64'(t));
    chk({nm, "_ready_low"}, 64'(rr), 64'd0);
    if (bus.resp_ready) tick();
  endtask

  task automatic do_op4(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed);
    int cyc;
    bus4.req_funct3 = f; bus4.req_a = a; bus4.req_b = b; bus4.req_tag = 5'd3; bus4.req_valid = 1'b1;
    chk({nm, "_accept_ready"}, 64'(bus4.req_ready), 64'd1);
    tick();
    bus4.req_valid = 1'b0;
    cyc = 1;
    while (!bus4.resp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'd9);
    chk({nm, "_data"}, 64'(bus4.resp_data), 64'(ed));
    tick();
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.resp_ready = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_funct3 = '0; bus4.req_a = '0; bus4.req_b = '0; bus4.req_tag = '0;
    bus4.resp_ready = 1'b1;
    repeat (3) tick();
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("reset_resp_data", 64'(bus.resp_data), 64'd0);
    chk("reset_resp_tag", 64'(bus.resp_tag), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", 64'(bus.req_ready), 64'd1);
    do_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd9, 32'hFFFFFFEB, 33);
    do_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 33);
    do_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33);
    do_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 5'd3, 32'hFFFFFFFF, 33);
    do_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, 33);
    do_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFF, 33);
    do_op("divu_by0", 3'b101, 32'd5, 32'd0, 5'd6, 32'hFFFFFFFF, 1);
    do_op("remu_by0", 3'b111, 32'd5, 32'd0, 5'd7, 32'd5, 1);
    do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, 1);
    do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'd0, 1);
    do_op("divu", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    bus.resp_ready = 1'b0;
    do_op("bp", 3'b000, 32'd6, 32'd7, 5'd12, 32'd42, 33);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_hold_data", 64'(bus.resp_data), 64'd42);
      chk("bp_hold_tag", 64'(bus.resp_tag), 64'd12);
      chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_release_ready", 64'(bus.req_ready), 64'd1);
    chk("bp_release_valid", 64'(bus.resp_valid), 64'd0);
    do_op("b2b", 3'b011, 32'h00010000, 32'h00010000, 5'd13, 32'd1, 33);
    kill = 1'b1; bus.req_valid = 1'b1; bus.req_funct3 = 3'b000; bus.req_a = 32'd3; bus.req_b = 32'd3;
    #1;
    chk("kill_idle_ready", 64'(bus.req_ready), 64'd0);
    tick();
    kill = 1'b0; bus.req_valid = 1'b0;
    chk("kill_idle_busy", 64'(busy), 64'd0);
    for (int pass = 0; pass < 2; pass++) begin
      logic seen;
      bus.req_funct3 = 3'b001; bus.req_a = 32'd5; bus.req_b = 32'd9; bus.req_tag = 5'd14; bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      repeat (9) tick();
      if (pass == 0) kill = 1'b1; else reset = 1'b1;
      tick();
      kill = 1'b0; reset = 1'b0;
      #1;
      chk(pass == 0 ? "kill_ready_c11" : "reset_ready_c11", 64'(bus.req_ready), 64'd1);
      chk(pass == 0 ? "kill_busy_c11" : "reset_busy_c11", 64'(busy), 64'd0);
      if (pass == 1) begin
        chk("reset_mid_data", 64'(bus.resp_data), 64'd0);
        chk("reset_mid_tag", 64'(bus.resp_tag), 64'd0);
      end
      seen = 1'b0;
      repeat (40) begin
        seen |= bus.resp_valid;
        tick();
      end
      chk(pass == 0 ? "kill_no_resp" : "reset_no_resp", 64'(seen), 64'd0);
    end
    do_op("after_kill", 3'b000, 32'd3, 32'd5, 5'd15, 32'd15, 33);
    do_op4("u4_divu", 3'b101, 32'd100, 32'd7, 32'd14);
    do_op4("u4_remu", 3'b111, 32'd100, 32'd7, 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
